// File: rtl/rng_bit_collector_if.sv
// Word stream from the collector FIFO to the consumer; valid/ready, transfer on valid&ready.
interface rng_bit_collector_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/rng_bit_collector.sv
// Von Neumann de-bias of raw RNG bits, packed MSB-first into WIDTH-bit words, buffered in a DEPTH FIFO.
// Word visible one cycle after its last raw sample; a completed word is dropped (sticky overflow) only when full with no pop.
module rng_bit_collector #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int RPT_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       raw_bit,
    input  logic                       raw_valid,
    rng_bit_collector_if.master        rd,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [7:0]                 discard_count,
    output logic                       overflow,
    output logic                       stuck_alarm
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]    RUN_LIM  = 8'(RPT_LIMIT);

    logic             have_first;
    logic             first_bit;
    logic [WIDTH-2:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             seen_raw;
    logic             prev_raw;
    logic [7:0]       run;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             pair_en;
    logic             emit;
    logic             same;
    logic [WIDTH-1:0] word;
    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic [7:0]       run_next;

    always_comb begin
        pair_en  = raw_valid && !stuck_alarm;
        emit     = pair_en && have_first && (first_bit != raw_bit);
        same     = pair_en && have_first && (first_bit == raw_bit);
        word     = {shreg, first_bit};
        push     = emit && (bit_cnt == LAST_BIT);
        pop      = rd.out_valid && rd.out_ready;
        full     = (count == FULL_CNT);
        wr_en    = push && (!full || pop);
        run_next = 8'd1;
        if (seen_raw && (raw_bit == prev_raw))
            run_next = (run >= RUN_LIM) ? run : run + 8'd1;
    end

    assign rd.out_data  = mem[rd_ptr];
    assign rd.out_valid = (count != '0);
    assign fifo_count   = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            have_first    <= 1'b0;
            first_bit     <= 1'b0;
            shreg         <= '0;
            bit_cnt       <= '0;
            seen_raw      <= 1'b0;
            prev_raw      <= 1'b0;
            run           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            discard_count <= '0;
            overflow      <= 1'b0;
            stuck_alarm   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // Health test sees every sample, even while frozen or holding a first bit.
            if (raw_valid) begin
                seen_raw <= 1'b1;
                prev_raw <= raw_bit;
                run      <= run_next;
                if (run_next == RUN_LIM) stuck_alarm <= 1'b1;
            end

            if (pair_en) begin
                have_first <= !have_first;
                if (!have_first) first_bit <= raw_bit;
            end

            if (same && discard_count != 8'hFF) discard_count <= discard_count + 8'd1;

            if (emit) begin
                shreg   <= word[WIDTH-2:0];
                bit_cnt <= push ? '0 : bit_cnt + 1'b1;
            end

            if (push && full && !pop) overflow <= 1'b1;

            if (wr_en) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            if (wr_en && !pop)      count <= count + 1'b1;
            else if (pop && !wr_en) count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_rng_bit_collector.sv
// Randomized and directed bench for rng_bit_collector against a queue-based reference model.
module tb_rng_bit_collector;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int RPT   = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic raw_bit = 1'b0;
    logic raw_valid = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [7:0] discard_count;
    logic overflow;
    logic stuck_alarm;

    rng_bit_collector_if #(.WIDTH(WIDTH)) bus ();

    rng_bit_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RPT_LIMIT(RPT)) dut (
        .clk(clk), .reset(reset), .raw_bit(raw_bit), .raw_valid(raw_valid),
        .rd(bus.master), .fifo_count(fifo_count), .discard_count(discard_count),
        .overflow(overflow), .stuck_alarm(stuck_alarm)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: raw samples gather into pairs, corrected bits into words, words into a queue.
    bit m_pair[$];
    bit m_bits[$];
    int m_fifo[$];
    int m_disc, m_run;
    bit m_ovf, m_alarm, m_seen, m_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pair.delete(); m_bits.delete(); m_fifo.delete();
        m_disc = 0; m_run = 0; m_ovf = 0; m_alarm = 0; m_seen = 0; m_last = 0;
    endtask

    task automatic model_edge(input bit rv, input bit rb, input bit rdy);
        bit was_full, popping, frozen;
        int w;
        was_full = (m_fifo.size() == DEPTH);
        popping  = rdy && (m_fifo.size() > 0);
        frozen   = m_alarm;
        if (popping) void'(m_fifo.pop_front());
        if (rv) begin
            if (m_seen && rb == m_last) m_run = (m_run < RPT) ? m_run + 1 : m_run;
            else m_run = 1;
            m_seen = 1;
            m_last = rb;
            if (!frozen) begin
                m_pair.push_back(rb);
                if (m_pair.size() == 2) begin
                    if (m_pair[0] != m_pair[1]) begin
                        m_bits.push_back(m_pair[0]);
                        if (m_bits.size() == WIDTH) begin
                            w = 0;
                            foreach (m_bits[i]) w = w * 2 + int'(m_bits[i]);
                            m_bits.delete();
                            if (was_full && !popping) m_ovf = 1;
                            else m_fifo.push_back(w);
                        end
                    end else if (m_disc < 255) begin
                        m_disc++;
                    end
                    m_pair.delete();
                end
            end
            if (m_run == RPT) m_alarm = 1;
        end
    endtask

    task automatic compare_all();
        check("out_valid", bus.out_valid, m_fifo.size() != 0);
        check("fifo_count", fifo_count, m_fifo.size());
        check("discard_count", discard_count, m_disc);
        check("overflow", overflow, m_ovf);
        check("stuck_alarm", stuck_alarm, m_alarm);
        if (m_fifo.size() != 0) check("out_data", bus.out_data, m_fifo[0]);
    endtask

    task automatic step(input bit rv, input bit rb, input bit rdy);
        @(negedge clk);
        raw_valid = rv;
        raw_bit = rb;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(rv, rb, rdy);
        #1 compare_all();
    endtask

    // Asserted mid-cycle to exercise the asynchronous path.
    task automatic do_reset();
        raw_valid = 0;
        bus.out_ready = 0;
        reset = 0;
        #1;
        model_clear();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_discard", discard_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_alarm", stuck_alarm, 0);
        check("rst_out_data", bus.out_data, 0);
        @(negedge clk);
        reset = 1;
    endtask

    task automatic feed_bit(input bit b, input bit rdy_last);
        step(1, b, 0);
        step(1, !b, rdy_last);
    endtask

    task automatic feed_word(input int w, input bit rdy_last);
        for (int i = WIDTH - 1; i >= 0; i--)
            feed_bit(((w >> i) & 1) != 0, (i == 0) ? rdy_last : 1'b0);
    endtask

    initial begin
        bit seq1[8]  = '{1,0,0,1,1,0,1,0};
        bit seq2[12] = '{0,0,1,1,1,0,0,1,0,1,1,0};
        int words[5] = '{4'hA, 4'h3, 4'hC, 4'h5, 4'h9};
        bus.out_ready = 0;
        model_clear();
        #2;
        do_reset();

        // Basic packing
        foreach (seq1[i]) step(1, seq1[i], 0);
        check("t1_data", bus.out_data, 4'b1011);
        check("t1_count", fifo_count, 1);
        check("t1_disc", discard_count, 0);

        do_reset();
        foreach (seq2[i]) step(1, seq2[i], 0);
        check("t2_data", bus.out_data, 4'b1001);
        check("t2_disc", discard_count, 2);
        check("t2_alarm", stuck_alarm, 0);

        // Overflow then drain
        do_reset();
        foreach (words[i]) feed_word(words[i], 0);
        check("t3_count", fifo_count, 4);
        check("t3_ovf", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check("t3_pop_data", bus.out_data, words[i]);
            step(0, 0, 1);
        end
        check("t3_empty", bus.out_valid, 0);

        // Full FIFO with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 4; i++) feed_word(words[i], 0);
        feed_word(words[4], 1);
        check("t4_count", fifo_count, 4);
        check("t4_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            check("t4_order", bus.out_data, words[i + 1]);
            step(0, 0, 1);
        end

        // Stuck source
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0);
            check("t5_alarm", stuck_alarm, i == 7);
        end
        for (int i = 0; i < 8; i++) feed_bit(1, 0);
        check("t5_frozen_count", fifo_count, 0);
        check("t5_frozen_disc", discard_count, 4);
        do_reset();
        check("t5_cleared", stuck_alarm, 0);

        // Partial word lost on reset
        feed_bit(1, 0); feed_bit(0, 0); feed_bit(1, 0);
        do_reset();
        feed_bit(0, 0); feed_bit(1, 0); feed_bit(1, 0);
        check("t6_partial", fifo_count, 0);
        feed_bit(0, 0);
        check("t6_word", bus.out_data, 4'b0110);
        check("t6_count", fifo_count, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) do_reset();
            step(($urandom % 4) != 0,
                 (i % 500 < 300) ? (($urandom % 2) != 0) : (($urandom % 8) != 0),
                 ($urandom % 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rng_bit_collector.md
Name: rng_bit_collector

Overview:
- Consumer end of the ring-oscillator random bit stream: takes raw sampled bits, removes bias with a von Neumann corrector, and packs the corrected bits into WIDTH-bit words.
- Buffers the words in a small FIFO and hands them to game logic (damage/hit rolls) over a valid/ready handshake.
- Runs a repetition-count health test on the raw stream and raises a sticky alarm if the source appears stuck.

Parameters:
- WIDTH, 4, bits per output word (2..8).
- DEPTH, 4, FIFO depth in words; power of 2, at least 2.
- RPT_LIMIT, 8, run length of identical raw bits that trips stuck_alarm (2..255).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- raw_bit  input  1  raw random bit; already synchronised upstream.
- raw_valid  input  1  raw_bit is sampled on each clk edge where this is 1.
- out_data  output  WIDTH  head FIFO word; valid only while out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this edge.
- fifo_count  output  $clog2(DEPTH)+1  number of words held.
- discard_count  output  8  pairs discarded as 00/11; saturates at 255.
- overflow  output  1  sticky; a completed word was dropped because the FIFO was full.
- stuck_alarm  output  1  sticky; the health test tripped.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0: out_valid, fifo_count, discard_count, overflow and stuck_alarm are all 0.
  - Pair state, shift register, bit counter, run counter and FIFO pointers are cleared.
  - A partial pair or partial word is lost.
  - The FIFO holds nothing after reset; out_data reads 0.
- Pair stage, active only when raw_valid=1 and stuck_alarm=0:
  - With no held bit: store raw_bit as the first bit and set have_first.
  - With a held bit: clear have_first, then compare.
    - If first != raw_bit, emit corrected bit = first (10 -> 1, 01 -> 0).
    - If first == raw_bit, emit nothing; discard_count += 1, saturating at 255.
- Packing:
  - On the edge that emits a bit, shift it in: shreg <= {shreg[WIDTH-2:0], bit}. The first emitted bit ends up as the MSB.
  - The bit counter increments on each emitted bit.
  - When the emitted bit is the WIDTH-th, the completed word {shreg[WIDTH-2:0], bit} is pushed on that same edge and the bit counter returns to 0.
  - Latency: out_valid=1 in the cycle after the edge that samples the final raw bit, assuming the FIFO was empty.
- FIFO:
  - out_data is the head word, driven from registers.
  - A pop happens on any edge with out_valid=1 and out_ready=1.
  - Push when full with a simultaneous pop: both happen, and the count stays at DEPTH.
  - Push when full with no pop: the word is dropped, overflow is set to 1, and the FIFO is unchanged.
  - Push and pop together when not full: both happen, and the count is unchanged.
  - Pointers wrap modulo DEPTH.
  - out_ready while empty has no effect.
  - Word order is strictly first in, first out.
- Health test, on every raw_valid edge including while have_first is set:
  - If raw_bit equals the previous sampled raw bit, run increments, saturating at RPT_LIMIT. Otherwise run becomes 1.
  - The first sample after reset gives run=1.
  - When run reaches RPT_LIMIT, stuck_alarm goes to 1 on that edge. It clears only on reset.
  - While stuck_alarm=1, the pair, pack and discard stages are frozen, so no new words are produced.
  - The FIFO still drains normally while the alarm is set.
  - The sample that trips the alarm is still processed by the pair stage.
- With raw_valid=0, all raw-side state holds.

Test Plan:
- WIDTH=4; raw 1,0,0,1,1,0,1,0 with raw_valid=1 and out_ready=0 -> after the 8th edge out_valid=1, out_data=4'b1011, fifo_count=1, discard_count=0.
- Raw 0,0,1,1,1,0,0,1,0,1,1,0 -> discard_count=2, one word 4'b1001, stuck_alarm stays 0 (longest run is 3).
- out_ready=0, then five complete words A,B,C,D,E -> fifo_count=4, overflow=1. Then out_ready=1 -> pops A,B,C,D in order, out_valid=0 after the 4th pop.
- FIFO full and out_ready=1 on the same edge a new word completes -> fifo_count stays 4, overflow stays 0, and the new word is read after the 3 older ones.
- RPT_LIMIT=8; eight consecutive raw 1s -> stuck_alarm=1 on the 8th edge. Further valid pairs 1,0 (repeated) leave fifo_count and discard_count unchanged. Reset clears the alarm.
- Three corrected bits collected, then reset pulsed low mid-cycle -> outputs 0 immediately. After release, 4 fresh corrected bits are needed for the first word, and the word contains no pre-reset bits.
